// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD engine.
// Holds the FSM state encoding, algorithm-select codes and a width helper.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// Single-step GCD datapath: one subtractive or Stein (binary) reduction.
// Purely combinational; the caller decides when to register the result.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b,
    output logic             inc_k,
    output logic             eq
);

    logic a_gt_b;
    logic a_even;
    logic b_even;

    assign eq     = (a == b);
    assign a_gt_b = (a > b);
    assign a_even = ~a[0];
    assign b_even = ~b[0];

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        next_a = a;
        next_b = b;
        inc_k  = 1'b0;

        if (!eq) begin
            if (mode == MODE_SUB) begin
                if (a_gt_b) next_a = a - b;
                else        next_b = b - a;
            end else begin
                if (a_even && b_even) begin
                    next_a = a >> 1;
                    next_b = b >> 1;
                    inc_k  = 1'b1;
                end else if (a_even) begin
                    next_a = a >> 1;
                end else if (b_even) begin
                    next_b = b >> 1;
                end else if (a_gt_b) begin
                    next_a = a - b;
                end else begin
                    next_b = b - a;
                end
            end
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD engine with valid/ready request and response channels.
// Selects subtractive or Stein reduction per request and reports the step count.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles,
    output logic             out_zero
);

    localparam int K_W = clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             inc_k;
    logic             eq;

    gcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a),
        .b      (b),
        .mode   (mode),
        .next_a (next_a),
        .next_b (next_b),
        .inc_k  (inc_k),
        .eq     (eq)
    );

    // Handshake flags decode state only, so reset drops out_valid immediately.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            mode       <= MODE_SUB;
            k          <= '0;
            cnt        <= '0;
            out_gcd    <= '0;
            out_cycles <= '0;
            out_zero   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a    <= in_a;
                        b    <= in_b;
                        mode <= in_mode;
                        k    <= '0;
                        cnt  <= '0;
                        if (in_a == '0 || in_b == '0) begin
                            out_gcd    <= in_a | in_b;
                            out_cycles <= '0;
                            out_zero   <= (in_a == '0) && (in_b == '0);
                            state      <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (eq) begin
                        // Binary mode restores the common power of two; cannot overflow.
                        out_gcd    <= (mode == MODE_BIN) ? (a << k) : a;
                        out_cycles <= cnt;
                        out_zero   <= 1'b0;
                        state      <= DONE;
                    end else begin
                        a <= next_a;
                        b <= next_b;
                        if (inc_k) k <= k + 1'b1;
                        if (cnt != '1) cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: vector table plus handshake, saturation
// and reset corner sequences against hand-computed results.
module tb_gcd_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 16;
    localparam int LIMIT = 500;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic [CNT_W-1:0] out_cycles;
    logic             out_zero;

    // Second instance with a narrow counter for the saturation case.
    logic             s_in_valid;
    logic             s_in_ready;
    logic [WIDTH-1:0] s_in_a;
    logic [WIDTH-1:0] s_in_b;
    logic             s_in_mode;
    logic             s_out_valid;
    logic             s_out_ready;
    logic [WIDTH-1:0] s_out_gcd;
    logic [3:0]       s_out_cycles;
    logic             s_out_zero;

    int errors = 0;
    int checks = 0;

    gcd_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_cycles (out_cycles),
        .out_zero   (out_zero)
    );

    gcd_unit #(.WIDTH(WIDTH), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_a       (s_in_a),
        .in_b       (s_in_b),
        .in_mode    (s_in_mode),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_gcd    (s_out_gcd),
        .out_cycles (s_out_cycles),
        .out_zero   (s_out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             mode;
        logic [WIDTH-1:0] gcd;
        int               cycles;
        logic             zero;
        int               lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents one request and waits for out_valid; latency counts the accept edge as 1.
    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic mode, output int lat);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{16'd12, 16'd18, 1'b0, 16'd6,  2, 1'b0, 4};
        vecs[1] = '{16'd12, 16'd18, 1'b1, 16'd6,  4, 1'b0, 6};
        vecs[2] = '{16'd48, 16'd36, 1'b1, 16'd12, 6, 1'b0, 8};
        vecs[3] = '{16'd0,  16'd7,  1'b0, 16'd7,  0, 1'b0, 1};
        vecs[4] = '{16'd0,  16'd0,  1'b1, 16'd0,  0, 1'b1, 1};
        vecs[5] = '{16'd5,  16'd0,  1'b0, 16'd5,  0, 1'b0, 1};
        vecs[6] = '{16'd7,  16'd7,  1'b0, 16'd7,  0, 1'b0, 2};
        vecs[7] = '{16'd64, 16'd16, 1'b1, 16'd16, 6, 1'b0, 8};
        vecs[8] = '{16'd3,  16'd1,  1'b0, 16'd1,  2, 1'b0, 4};
        vecs[9] = '{16'd15, 16'd5,  1'b1, 16'd5,  2, 1'b0, 4};

        reset       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_mode     = 1'b0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_a      = '0;
        s_in_b      = '0;
        s_in_mode   = 1'b0;
        s_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_gcd", {16'd0, out_gcd}, 32'd0);
        check("rst_out_cycles", {16'd0, out_cycles}, 32'd0);
        check("rst_out_zero", {31'd0, out_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].mode, lat);
            check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_gcd", i), {16'd0, out_gcd}, {16'd0, vecs[i].gcd});
            check($sformatf("v%0d_cycles", i), {16'd0, out_cycles}, vecs[i].cycles);
            check($sformatf("v%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].zero});
            check($sformatf("v%0d_busy", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_idle", i), {31'd0, in_ready}, 32'd1);
            check($sformatf("v%0d_drop", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-pressure: result must hold while stray requests are ignored.
        out_ready = 1'b0;
        run_txn(16'd12, 16'd18, 1'b0, lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'd100 + 16'(i);
            in_b     = 16'd3;
            in_mode  = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("bp%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_gcd", i), {16'd0, out_gcd}, 32'd6);
            check($sformatf("bp%0d_cycles", i), {16'd0, out_cycles}, 32'd2);
            check($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_no_phantom", {31'd0, out_valid}, 32'd0);

        // Narrow counter: 99 subtract steps saturate at 15.
        @(negedge clk);
        s_in_a     = 16'd100;
        s_in_b     = 16'd1;
        s_in_mode  = 1'b0;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("sat_valid", {31'd0, s_out_valid}, 32'd1);
        check("sat_latency", lat, 101);
        check("sat_gcd", {16'd0, s_out_gcd}, 32'd1);
        check("sat_cycles", {28'd0, s_out_cycles}, 32'd15);
        @(posedge clk);
        #1;
        check("sat_idle", {31'd0, s_in_ready}, 32'd1);

        // Reset in the middle of a long subtractive run.
        @(negedge clk);
        in_a     = 16'd65535;
        in_b     = 16'd1;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_run_busy", {31'd0, in_ready}, 32'd0);
        check("mid_run_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_gcd", {16'd0, out_gcd}, 32'd0);
        run_txn(16'd9, 16'd6, 1'b0, lat);
        check("after_rst_latency", lat, 4);
        check("after_rst_gcd", {16'd0, out_gcd}, 32'd3);
        check("after_rst_cycles", {16'd0, out_cycles}, 32'd2);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
